alu_mc: RTL and testbench



---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_mc_if.sv | 32 +++
 rtl/alu_muldiv_iter.sv | 136 +++++++++++++
 rtl/alu_mc.sv | 150 +++++++++++++++
 tb/tb_alu_mc.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcode map, FSM states, debug view
// and the helper that tells the FSM which opcodes take the iterative path.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_DIV = 3'd3,
    OP_AND = 3'd4,
    OP_OR  = 3'd5,
    OP_XOR = 3'd6,
    OP_MOD = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Wide enough for DATA_WIDTH up to 32.
  localparam int CNT_W = 6;

  typedef struct packed {
    state_e             state;
    logic [CNT_W-1:0]   cnt;
    logic               iter_done;
  } dbg_t;

  function automatic logic is_iter(op_e op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Issue/result bus of the multi-cycle ALU. master = issue stage plus result
// consumer, slave = the ALU.
interface alu_mc_if #(
  parameter int DATA_WIDTH = 8
);
  localparam int RES_WIDTH = 2*DATA_WIDTH + 1;

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // The producer holds its payload stable while valid && !ready; ready may
  // depend on state only, never combinationally on valid.
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            sel;
  logic [DATA_WIDTH-1:0] in0;
  logic [DATA_WIDTH-1:0] in1;
  logic                  out_valid;
  logic                  out_ready;
  logic [RES_WIDTH-1:0]  out;
  logic                  zero;
  logic                  div_by_zero;

  modport master (
    output in_valid, sel, in0, in1, out_ready,
    input  in_ready, out_valid, out, zero, div_by_zero
  );

  modport slave (
    input  in_valid, sel, in0, in1, out_ready,
    output in_ready, out_valid, out, zero, div_by_zero
  );

endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier and restoring divider. The first iteration
// runs on the start edge itself, so results are final DATA_WIDTH-1 edges later.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  op_e                     op,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic                    done,
  output logic [2*DATA_WIDTH-1:0] product,
  output logic [DATA_WIDTH-1:0]   quotient,
  output logic [DATA_WIDTH-1:0]   remainder
);

  localparam int DW = DATA_WIDTH;

  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                mul_q, mul_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DW-1:0]     acc_q, acc_d;
  logic [2*DW-1:0]     mcand_q, mcand_d;
  logic [DW-1:0]       mplier_q, mplier_d;
  logic [DW-1:0]       rem_q, rem_d;
  logic [DW-1:0]       quo_q, quo_d;
  logic [DW-1:0]       dvsr_q, dvsr_d;

  // Iteration source: fresh operands on start, registered state otherwise.
  logic                c_mul;
  logic [2*DW-1:0]     c_acc, c_mcand;
  logic [DW-1:0]       c_mplier, c_rem, c_quo, c_dvsr;
  logic [DW:0]         rem_sh;
  logic [DW+1:0]       trial;

  always_comb begin
    busy_d   = busy_q;
    done_d   = 1'b0;
    mul_d    = mul_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    rem_sh   = '0;
    trial    = '0;

    if (start) begin
      c_mul    = (op == OP_MUL);
      c_acc    = '0;
      c_mcand  = (2*DW)'(a);
      c_mplier = b;
      c_rem    = '0;
      c_quo    = a;
      c_dvsr   = b;
    end else begin
      c_mul    = mul_q;
      c_acc    = acc_q;
      c_mcand  = mcand_q;
      c_mplier = mplier_q;
      c_rem    = rem_q;
      c_quo    = quo_q;
      c_dvsr   = dvsr_q;
    end

    if (start || busy_q) begin
      mul_d = c_mul;
      if (c_mul) begin
        acc_d    = c_mplier[0] ? (c_acc + c_mcand) : c_acc;
        mcand_d  = c_mcand << 1;
        mplier_d = c_mplier >> 1;
      end else begin
        // Bring in the next dividend bit, keep the trial difference if no borrow.
        rem_sh = {c_rem, c_quo[DW-1]};
        trial  = {1'b0, rem_sh} - {2'b00, c_dvsr};
        dvsr_d = c_dvsr;
        if (!trial[DW+1]) begin
          rem_d = trial[DW-1:0];
          quo_d = {c_quo[DW-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[DW-1:0];
          quo_d = {c_quo[DW-2:0], 1'b0};
        end
      end
    end

    if (start) begin
      busy_d = 1'b1;
      cnt_d  = CNT_W'(DW - 1);
    end else if (busy_q) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mul_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
    end else begin
      busy_q   <= busy_d;
      done_q   <= done_d;
      mul_q    <= mul_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
    end
  end

  assign done      = done_q;
  assign product   = acc_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle 8-op ALU: handshake FSM, single-cycle ops, flags and the output
// register; MUL/DIV/MOD are delegated to alu_muldiv_iter.
module alu_mc
  import alu_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  localparam int RES_WIDTH  = 2*DATA_WIDTH + 1
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_mc_if.slave   bus,
  output dbg_t      dbg
);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  op_e                    op_q, op_d;
  logic [RES_WIDTH-1:0]   out_q, out_d;
  logic                   zero_q, zero_d;
  logic                   dbz_q, dbz_d;

  op_e                    sel_op;
  logic                   start;
  logic                   div0;
  logic [RES_WIDTH-1:0]   a_ext, b_ext;
  logic [RES_WIDTH-1:0]   single_res;
  logic [RES_WIDTH-1:0]   iter_res;
  logic                   mdone;
  logic [2*DATA_WIDTH-1:0] product;
  logic [DATA_WIDTH-1:0]  quotient;
  logic [DATA_WIDTH-1:0]  remainder;

  assign sel_op = op_e'(bus.sel);
  assign a_ext  = RES_WIDTH'(bus.in0);
  assign b_ext  = RES_WIDTH'(bus.in1);
  assign div0   = ((sel_op == OP_DIV) || (sel_op == OP_MOD)) && (bus.in1 == '0);

  // SUB wraps in RES_WIDTH bits, which is the sign-carried difference.
  always_comb begin
    case (sel_op)
      OP_ADD:  single_res = a_ext + b_ext;
      OP_SUB:  single_res = a_ext - b_ext;
      OP_AND:  single_res = a_ext & b_ext;
      OP_OR:   single_res = a_ext | b_ext;
      OP_XOR:  single_res = a_ext ^ b_ext;
      default: single_res = '0;
    endcase
  end

  always_comb begin
    case (op_q)
      OP_MUL:  iter_res = RES_WIDTH'(product);
      OP_DIV:  iter_res = RES_WIDTH'(quotient);
      OP_MOD:  iter_res = RES_WIDTH'(remainder);
      default: iter_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    out_d   = out_q;
    zero_d  = zero_q;
    dbz_d   = dbz_q;
    start   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          op_d = sel_op;
          if (div0) begin
            out_d   = '0;
            zero_d  = 1'b1;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else if (is_iter(sel_op)) begin
            start   = 1'b1;
            cnt_d   = CNT_W'(DATA_WIDTH);
            state_d = BUSY;
          end else begin
            out_d   = single_res;
            zero_d  = (single_res == '0);
            dbz_d   = 1'b0;
            state_d = DONE;
          end
        end
      end
      BUSY: begin
        // The iterator finishes on the same edge the counter reaches 1.
        if (cnt_q == CNT_W'(1)) begin
          out_d   = iter_res;
          zero_d  = (iter_res == '0);
          dbz_d   = 1'b0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_ADD;
      out_q   <= '0;
      zero_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
      dbz_q   <= dbz_d;
    end
  end

  alu_muldiv_iter #(.DATA_WIDTH(DATA_WIDTH)) u_iter (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (sel_op),
    .a         (bus.in0),
    .b         (bus.in1),
    .done      (mdone),
    .product   (product),
    .quotient  (quotient),
    .remainder (remainder)
  );

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.out         = out_q;
  assign bus.zero        = zero_q;
  assign bus.div_by_zero = dbz_q;

  always_comb begin
    dbg.state     = state_q;
    dbg.cnt       = cnt_q;
    dbg.iter_done = mdone;
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc (DATA_WIDTH=8): latency, arithmetic, flags,
// backpressure and asynchronous reset mid-operation.
module tb_alu_mc;
  import alu_pkg::*;

  localparam int DW = 8;
  localparam int RW = 2*DW + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   compared = 0;
  int   mismatched = 0;
  logic [RW-1:0] exp_q[$];
  dbg_t dbg;

  alu_mc_if #(.DATA_WIDTH(DW)) bus();

  alu_mc #(.DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .dbg   (dbg)
  );

  // Clock
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one op, measure latency, check the result; if consume is set the
  // result is taken on the first valid cycle and the return to IDLE is checked.
  task automatic run_op(input string tag, input logic [2:0] s,
                        input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [RW-1:0] exp_out, input logic exp_z,
                        input logic exp_dbz, input int exp_lat, input logic consume);
    int lat;
    logic ready_seen;
    logic [RW-1:0] e;
    exp_q.push_back(exp_out);
    @(negedge clk);
    check({tag, " in_ready_before"}, 32'(bus.in_ready), 32'd1);
    bus.sel       = s;
    bus.in0       = a;
    bus.in1       = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = consume;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.sel      = 3'($urandom_range(0, 7));
    lat        = 1;
    ready_seen = 1'b0;
    while (!bus.out_valid && lat < 64) begin
      if (bus.in_ready) ready_seen = 1'b1;
      bus.in0 = DW'($urandom_range(0, 255));
      bus.in1 = DW'($urandom_range(0, 255));
      @(posedge clk);
      #1;
      lat++;
    end
    e = exp_q.pop_front();
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " in_ready_busy"}, 32'(ready_seen), 32'd0);
    check({tag, " out"}, 32'(bus.out), 32'(e));
    check({tag, " zero"}, 32'(bus.zero), 32'(exp_z));
    check({tag, " div_by_zero"}, 32'(bus.div_by_zero), 32'(exp_dbz));
    check({tag, " in_ready_done"}, 32'(bus.in_ready), 32'd0);
    if (consume) begin
      @(posedge clk);
      #1;
      check({tag, " out_valid_after"}, 32'(bus.out_valid), 32'd0);
      check({tag, " in_ready_after"}, 32'(bus.in_ready), 32'd1);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.sel       = 3'd0;
    bus.in0       = '0;
    bus.in1       = '0;
    bus.out_ready = 1'b0;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset in_ready", 32'(bus.in_ready), 32'd1);
    check("reset out", 32'(bus.out), 32'd0);
    check("reset zero", 32'(bus.zero), 32'd0);
    check("reset dbz", 32'(bus.div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-cycle ops
    run_op("add_200_100", 3'd0, 8'd200, 8'd100, 17'd300,    1'b0, 1'b0, 1, 1'b1);
    run_op("add_255_255", 3'd0, 8'd255, 8'd255, 17'd510,    1'b0, 1'b0, 1, 1'b1);
    run_op("sub_3_5",     3'd1, 8'd3,   8'd5,   17'h1FFFE,  1'b0, 1'b0, 1, 1'b1);
    run_op("sub_7_7",     3'd1, 8'd7,   8'd7,   17'd0,      1'b1, 1'b0, 1, 1'b1);
    run_op("and_f0_3c",   3'd4, 8'hF0,  8'h3C,  17'h00030,  1'b0, 1'b0, 1, 1'b1);
    run_op("or_f0_3c",    3'd5, 8'hF0,  8'h3C,  17'h000FC,  1'b0, 1'b0, 1, 1'b1);

    // Iterative ops
    run_op("mul_255_255", 3'd2, 8'd255, 8'd255, 17'd65025,  1'b0, 1'b0, 9, 1'b1);
    run_op("mul_0_17",    3'd2, 8'd0,   8'd17,  17'd0,      1'b1, 1'b0, 9, 1'b1);
    run_op("mul_13_11",   3'd2, 8'd13,  8'd11,  17'd143,    1'b0, 1'b0, 9, 1'b1);
    run_op("div_200_7",   3'd3, 8'd200, 8'd7,   17'd28,     1'b0, 1'b0, 9, 1'b1);
    run_op("mod_200_7",   3'd7, 8'd200, 8'd7,   17'd4,      1'b0, 1'b0, 9, 1'b1);
    run_op("div_7_200",   3'd3, 8'd7,   8'd200, 17'd0,      1'b1, 1'b0, 9, 1'b1);
    run_op("mod_7_200",   3'd7, 8'd7,   8'd200, 17'd7,      1'b0, 1'b0, 9, 1'b1);
    run_op("div_255_1",   3'd3, 8'd255, 8'd1,   17'd255,    1'b0, 1'b0, 9, 1'b1);

    // Divide by zero short-circuits
    run_op("div_5_0",     3'd3, 8'd5,   8'd0,   17'd0,      1'b1, 1'b1, 1, 1'b1);
    run_op("mod_5_0",     3'd7, 8'd5,   8'd0,   17'd0,      1'b1, 1'b1, 1, 1'b1);

    // Backpressure: result held, extra in_valid pulses ignored
    run_op("xor_bp",      3'd6, 8'hF0,  8'h3C,  17'd204,    1'b0, 1'b0, 1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = i[0];
      bus.sel      = 3'd0;
      bus.in0      = DW'($urandom_range(1, 255));
      bus.in1      = DW'($urandom_range(1, 255));
      @(posedge clk);
      #1;
      check("bp out", 32'(bus.out), 32'd204);
      check("bp out_valid", 32'(bus.out_valid), 32'd1);
      check("bp in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp release out_valid", 32'(bus.out_valid), 32'd0);
    check("bp release in_ready", 32'(bus.in_ready), 32'd1);

    // Asynchronous reset in the middle of a MUL
    @(negedge clk);
    bus.sel      = 3'd2;
    bus.in0      = 8'd200;
    bus.in1      = 8'd100;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    check("rst pre state", 32'(dbg.state), 32'(BUSY));
    rst_n = 1'b0;
    #1;
    check("rst async state", 32'(dbg.state), 32'(IDLE));
    check("rst async out_valid", 32'(bus.out_valid), 32'd0);
    check("rst async out", 32'(bus.out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst release out_valid", 32'(bus.out_valid), 32'd0);
    check("rst release in_ready", 32'(bus.in_ready), 32'd1);
    check("rst release out", 32'(bus.out), 32'd0);
    run_op("add_1_1",     3'd0, 8'd1,   8'd1,   17'd2,      1'b0, 1'b0, 1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
